fp_pack_result: RTL and testbench

Final stage of the floating-point adder pipeline: the encoder counterpart of the first-stage special-value classifier. It takes the 2-bit special code produced by that stage together with the normalized sign, exponent and significand from the datapath. It rounds (round-to-nearest-even), detects overflow and underflow, overrides with special encodings, and emits a packed IEEE-style word. It has two registered stages with valid/ready flow control and sticky exception flags.

---
 rtl/fp_pack_result.sv | 164 ++++++++++++++++
 tb/tb_fp_pack_result.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_pack_result.sv
// rtl/fp_pack_result.sv - FP adder final stage: RNE rounding, special override and IEEE packing
`ifndef FP_PACK_DEFS
`define FP_PACK_DEFS
`define FP32 0
`define FP64 1
`define FP16 2
`define GET_FP_LEN(f) ((f) == 1 ? 64 : ((f) == 2 ? 16 : 32))
`define GET_EXP_LEN(f) ((f) == 1 ? 11 : ((f) == 2 ? 5 : 8))
`define NORMAL 2'b00
`define ZERO 2'b01
`define INF 2'b10
`define NAN 2'b11
`endif

module fp_pack_result #(
    parameter int data_format = `FP32,
    localparam int L = `GET_FP_LEN(data_format),
    localparam int E = `GET_EXP_LEN(data_format),
    localparam int M = L - 1 - E
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [1:0]   i_special,
    input  logic         i_sign,
    input  logic [E+1:0] i_exp,
    input  logic [M+3:0] i_mant,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [L-1:0] o_out_data,
    input  logic         i_flag_clr,
    output logic [3:0]   o_flags
);

    localparam logic [E+1:0] EXP_MAX = (E+2)'((1 << E) - 1);
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    logic         w_round_up;
    logic [M:0]   w_frac_sum;
    logic         w_carry;
    logic [E+1:0] w_exp_adj;
    logic         w_inexact;

    logic         r_s1_valid;
    logic [1:0]   r_s1_special;
    logic         r_s1_sign;
    logic [E+1:0] r_s1_exp;
    logic [M-1:0] r_s1_frac;
    logic         r_s1_inexact;

    logic         r_out_valid;
    logic [L-1:0] r_out_data;
    logic [3:0]   r_s2_evt;
    logic [3:0]   r_flags;

    logic         w_s2_ready;
    logic         w_s1_advance;
    logic         w_handoff;
    logic         w_exp_ovf;
    logic         w_exp_unf;
    logic [L-1:0] w_pack_data;
    logic [3:0]   w_pack_evt;

    // Rounding only the fraction: a carry out of it into a set hidden bit is
    // exactly the significand overflow to 10.000..0, and the low M bits are
    // already the zero fraction of the renormalized 1.000..0.
    assign w_round_up = i_mant[2] & (i_mant[1] | i_mant[0] | i_mant[3]);
    assign w_frac_sum = {1'b0, i_mant[M+2:3]} + {{M{1'b0}}, w_round_up};
    assign w_carry    = i_mant[M+3] & w_frac_sum[M];
    assign w_exp_adj  = i_exp + {{(E+1){1'b0}}, w_carry};
    assign w_inexact  = |i_mant[2:0];

    assign w_s2_ready   = !r_out_valid | i_out_ready;
    assign w_s1_advance = r_s1_valid & w_s2_ready;
    assign w_handoff    = r_out_valid & i_out_ready;
    assign o_in_ready   = !r_s1_valid | w_s1_advance;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_special <= `NORMAL;
            r_s1_sign    <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_frac    <= '0;
            r_s1_inexact <= 1'b0;
        end else if (o_in_ready) begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_s1_special <= i_special;
                r_s1_sign    <= i_sign;
                r_s1_exp     <= w_exp_adj;
                r_s1_frac    <= w_frac_sum[M-1:0];
                r_s1_inexact <= w_inexact;
            end
        end
    end

    // Exponent is two's complement; negative or zero means no normal encoding.
    assign w_exp_unf = r_s1_exp[E+1] | (r_s1_exp == '0);
    assign w_exp_ovf = !r_s1_exp[E+1] & (r_s1_exp >= EXP_MAX);

    always_comb begin
        w_pack_data = '0;
        w_pack_evt  = '0;
        case (r_s1_special)
            `NAN: begin
                w_pack_data = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
                w_pack_evt[FLAG_INVALID] = 1'b1;
            end
            `INF: begin
                w_pack_data = {r_s1_sign, {E{1'b1}}, {M{1'b0}}};
            end
            `ZERO: begin
                w_pack_data = {r_s1_sign, {(L-1){1'b0}}};
            end
            default: begin
                if (w_exp_ovf) begin
                    w_pack_data = {r_s1_sign, {E{1'b1}}, {M{1'b0}}};
                    w_pack_evt[FLAG_OVERFLOW] = 1'b1;
                    w_pack_evt[FLAG_INEXACT]  = 1'b1;
                end else if (w_exp_unf) begin
                    w_pack_data = {r_s1_sign, {(L-1){1'b0}}};
                    w_pack_evt[FLAG_UNDERFLOW] = 1'b1;
                    w_pack_evt[FLAG_INEXACT]   = 1'b1;
                end else begin
                    w_pack_data = {r_s1_sign, r_s1_exp[E-1:0], r_s1_frac};
                    w_pack_evt[FLAG_INEXACT] = r_s1_inexact;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_s2_evt    <= '0;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_pack_data;
                r_s2_evt   <= w_pack_evt;
            end
        end
    end

    // Events travel with their beat and only count once the result is taken.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flags <= '0;
        end else begin
            r_flags <= (i_flag_clr ? 4'b0000 : r_flags) | (w_handoff ? r_s2_evt : 4'b0000);
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_flags     = r_flags;

endmodule

// File: tb/tb_fp_pack_result.sv
// tb/tb_fp_pack_result.sv - self-checking bench for fp_pack_result (FP32)
`ifndef FP_PACK_DEFS
`define FP_PACK_DEFS
`define FP32 0
`define FP64 1
`define FP16 2
`define GET_FP_LEN(f) ((f) == 1 ? 64 : ((f) == 2 ? 16 : 32))
`define GET_EXP_LEN(f) ((f) == 1 ? 11 : ((f) == 2 ? 5 : 8))
`define NORMAL 2'b00
`define ZERO 2'b01
`define INF 2'b10
`define NAN 2'b11
`endif

module tb_fp_pack_result;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  special;
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        flag_clr;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    fp_pack_result #(.data_format(`FP32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_special   (special),
        .i_sign      (sign),
        .i_exp       (exp),
        .i_mant      (mant),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .i_flag_clr  (flag_clr),
        .o_flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sp;
        logic        sg;
        logic [9:0]  ex;
        logic [26:0] mn;
        logic [31:0] d;
        logic [3:0]  f;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [1:0] sp, input logic sg, input logic [9:0] ex, input logic [26:0] mn);
        special = sp;
        sign    = sg;
        exp     = ex;
        mant    = mn;
    endtask

    // Reference: integer significand with a round-half-to-even tie rule.
    function automatic void model(input logic [1:0] sp, input logic sg, input logic [9:0] ex,
                                  input logic [26:0] mn, output logic [31:0] d, output logic [3:0] f);
        int    e;
        longint sig;
        int    grs;
        e   = int'($signed(ex));
        sig = longint'(mn >> 3);
        grs = int'(mn & 27'd7);
        if (grs > 4 || (grs == 4 && (sig % 2) == 1)) sig = sig + 1;
        if (sig >= (longint'(1) << 24)) begin
            sig = sig / 2;
            e   = e + 1;
        end
        case (sp)
            `NAN:  begin d = 32'h7FC00000;         f = 4'b1000; end
            `INF:  begin d = {sg, 8'hFF, 23'h0};   f = 4'b0000; end
            `ZERO: begin d = {sg, 31'h0};          f = 4'b0000; end
            default: begin
                if (e >= 255) begin
                    d = {sg, 8'hFF, 23'h0}; f = 4'b0101;
                end else if (e <= 0) begin
                    d = {sg, 31'h0};        f = 4'b0011;
                end else begin
                    d = {sg, 8'(e), 23'(sig)};
                    f = {3'b000, grs != 0};
                end
            end
        endcase
    endfunction

    task automatic run_beat(input logic [1:0] sp, input logic sg, input logic [9:0] ex, input logic [26:0] mn,
                            output logic [31:0] d, output logic [3:0] f, output int lat);
        int w;
        set_beat(sp, sg, ex, mn);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin tick(); w++; end
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        d = out_data;
        tick();
        f = flags;
    endtask

    task automatic clear_flags();
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
    endtask

    vec_t        vecs[$];
    logic [31:0] q[$];
    logic [31:0] d_got, d_exp;
    logic [3:0]  f_got, f_exp, m_flags;
    int          lat, acc, got, k, budget;
    logic [1:0]  r_sp;
    logic        r_sg;
    logic [9:0]  r_ex;
    logic [26:0] r_mn;

    initial begin
        vecs.push_back('{`NORMAL, 1'b0, 10'd127, 27'h4000000, 32'h3F800000, 4'b0000});
        vecs.push_back('{`NORMAL, 1'b0, 10'd127, 27'h4000004, 32'h3F800000, 4'b0001});
        vecs.push_back('{`NORMAL, 1'b0, 10'd127, 27'h400000C, 32'h3F800002, 4'b0001});
        vecs.push_back('{`NORMAL, 1'b0, 10'd127, 27'h4000014, 32'h3F800002, 4'b0001});
        vecs.push_back('{`NORMAL, 1'b0, 10'd127, 27'h4000005, 32'h3F800001, 4'b0001});
        vecs.push_back('{`NORMAL, 1'b0, 10'd127, 27'h7FFFFFE, 32'h40000000, 4'b0001});
        vecs.push_back('{`NORMAL, 1'b0, 10'd254, 27'h7FFFFFE, 32'h7F800000, 4'b0101});
        vecs.push_back('{`NORMAL, 1'b0, 10'd255, 27'h4000000, 32'h7F800000, 4'b0101});
        vecs.push_back('{`NORMAL, 1'b0, 10'd254, 27'h491A2B3, 32'h7F123456, 4'b0001});
        vecs.push_back('{`NAN,    1'b1, 10'd77,  27'h0000000, 32'h7FC00000, 4'b1000});
        vecs.push_back('{`INF,    1'b1, 10'd0,   27'h0000007, 32'hFF800000, 4'b0000});
        vecs.push_back('{`ZERO,   1'b1, 10'd0,   27'h0000007, 32'h80000000, 4'b0000});
        vecs.push_back('{`NORMAL, 1'b0, 10'd0,   27'h4000000, 32'h00000000, 4'b0011});
        vecs.push_back('{`NORMAL, 1'b1, 10'h3FB, 27'h4000000, 32'h80000000, 4'b0011});
        vecs.push_back('{`NORMAL, 1'b0, 10'd1,   27'h4000000, 32'h00800000, 4'b0000});

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
        set_beat(`NORMAL, 1'b0, 10'd0, 27'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_flags", flags, 0);
        check("reset_in_ready", in_ready, 1);
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            clear_flags();
            run_beat(vecs[i].sp, vecs[i].sg, vecs[i].ex, vecs[i].mn, d_got, f_got, lat);
            check($sformatf("vec%0d_data", i), d_got, vecs[i].d);
            check($sformatf("vec%0d_flags", i), f_got, vecs[i].f);
            check($sformatf("vec%0d_latency", i), lat, 2);
        end

        // Randomized streaming with random backpressure against the reference model.
        clear_flags();
        m_flags = 4'b0000;
        acc = 0;
        for (int cyc = 0; cyc < 1500 && acc < 300; cyc++) begin
            case ($urandom_range(0, 9))
                7:       r_sp = `NAN;
                8:       r_sp = `INF;
                9:       r_sp = `ZERO;
                default: r_sp = `NORMAL;
            endcase
            case ($urandom_range(0, 3))
                0:       r_ex = 10'(int'($urandom_range(0, 4)) - 2);
                1:       r_ex = 10'(int'($urandom_range(252, 256)));
                default: r_ex = 10'(int'($urandom_range(0, 512)) - 256);
            endcase
            r_sg = 1'($urandom);
            r_mn = 27'($urandom);
            if (r_sp == `NORMAL) r_mn[26] = 1'b1;
            set_beat(r_sp, r_sg, r_ex, r_mn);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rand_extra_output: got 0x%08h, expected no beat", out_data);
                end else begin
                    check("rand_data", out_data, q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                model(r_sp, r_sg, r_ex, r_mn, d_exp, f_exp);
                q.push_back(d_exp);
                m_flags = m_flags | f_exp;
                acc++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            if (out_valid) check("rand_drain_data", out_data, q.pop_front());
            tick();
            budget++;
        end
        check("rand_all_drained", q.size(), 0);
        check("rand_flags", flags, m_flags);

        // Backpressure: 4 distinct beats offered while the output is stalled.
        tick();
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            set_beat(`NORMAL, 1'b0, 10'(127 + k), 27'h4000000);
            in_valid = (k < 4);
            #1;
            if (in_valid && in_ready) k++;
            @(posedge clk);
            #1;
        end
        check("bp_accepted", k, 2);
        check("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        got = 0;
        budget = 0;
        while (got < 4 && budget < 30) begin
            set_beat(`NORMAL, 1'b0, 10'(127 + k), 27'h4000000);
            in_valid = (k < 4);
            #1;
            if (out_valid && out_ready) begin
                check($sformatf("bp_beat%0d", got), out_data, 32'h3F800000 + (got << 23));
                got++;
            end
            if (in_valid && in_ready) k++;
            @(posedge clk);
            #1;
            budget++;
        end
        in_valid = 1'b0;
        check("bp_beats_out", got, 4);
        tick();
        tick();
        check("bp_no_duplicate", out_valid, 0);

        // Same-cycle clear and overflow event: the event must survive.
        clear_flags();
        run_beat(`NORMAL, 1'b0, 10'd254, 27'h7FFFFFE, d_got, f_got, lat);
        check("ovf1_flags", f_got, 4'b0101);
        set_beat(`NORMAL, 1'b0, 10'd300, 27'h4000000);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        budget = 0;
        while (!out_valid && budget < 20) begin tick(); budget++; end
        check("ovf2_valid", out_valid, 1);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("clr_with_event", flags, 4'b0101);
        clear_flags();
        check("clr_alone", flags, 4'b0000);

        // Reset in the middle of stalled traffic.
        run_beat(`NAN, 1'b0, 10'd0, 27'd0, d_got, f_got, lat);
        check("pre_rst_flags", f_got, 4'b1000);
        out_ready = 1'b0;
        set_beat(`INF, 1'b0, 10'd0, 27'd0);
        in_valid = 1'b1;
        tick();
        tick();
        check("pre_rst_out_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_flags", flags, 0);
        check("rst_out_data", out_data, 0);
        in_valid = 1'b0;
        #3 rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        tick();
        check("post_rst_discarded", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
